// File: rtl/gpu_pkg.sv
// Shared GPU definitions: VRAM geometry defaults and the read-owner encoding
// used by the VRAM arbiter, VGA controller and sprite engine.
package gpu_pkg;

    localparam int VRAM_ADDR_W = 16;
    localparam int VRAM_DATA_W = 24;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the display fetch and the CPU. Display has
// priority during active video (bounded by a starve counter); blanking is round-robin.
module vram_arbiter
    import gpu_pkg::*;
#(
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int DATA_W       = VRAM_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hbright,
    input  logic              vbright,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    owner_e           last_grant;
    owner_e           owner_q;
    owner_e           owner_d;
    logic [CNT_W-1:0] starve_cnt;
    logic             active;
    logic             gnt_disp;
    logic             gnt_cpu;

    assign active = hbright && vbright;

    always_comb begin
        // NOTE: both grants get a default first so every path assigns them and no latch is inferred.
        gnt_disp = 1'b0;
        gnt_cpu  = 1'b0;
        if (disp_req && cpu_req) begin
            if (active) begin
                if (starve_cnt == LIMIT) gnt_cpu = 1'b1;
                else                     gnt_disp = 1'b1;
            end else if (last_grant == OWN_DISP) begin
                gnt_cpu = 1'b1;
            end else begin
                gnt_disp = 1'b1;
            end
        end else begin
            gnt_disp = disp_req;
            gnt_cpu  = cpu_req;
        end
    end

    // Grant, ack and the memory command are registered together; address/data hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_ack   <= 1'b0;
            cpu_ack    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            last_grant <= OWN_CPU;
            starve_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            disp_ack <= gnt_disp;
            cpu_ack  <= gnt_cpu;
            mem_en   <= gnt_disp || gnt_cpu;
            mem_we   <= gnt_cpu && cpu_we;
            if (gnt_disp) begin
                mem_addr   <= disp_addr;
                last_grant <= OWN_DISP;
            end else if (gnt_cpu) begin
                mem_addr   <= cpu_addr;
                mem_wdata  <= cpu_wdata;
                last_grant <= OWN_CPU;
            end
            if (gnt_cpu || !cpu_req)
                starve_cnt <= '0;
            else if (gnt_disp && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Owner FSM: names who receives the word the RAM returns in the current cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) owner_q <= OWN_NONE;
        else      owner_q <= owner_d;
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (mem_en && !mem_we)
            owner_d = last_grant;
    end

    always_comb begin
        disp_rvalid = (owner_q == OWN_DISP);
        cpu_rvalid  = (owner_q == OWN_CPU);
        disp_rdata  = disp_rvalid ? mem_rdata : '0;
        cpu_rdata   = cpu_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a behavioural arbitration model predicts each
// grant and read return, and a negedge monitor compares them against the DUT.
module tb_vram_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 24;
    localparam int LIMIT  = 8;

    typedef struct {
        int          who;
        int          cyc;
        logic        we;
        logic [15:0] addr;
        logic [23:0] wdata;
    } grant_t;

    typedef struct {
        int          who;
        int          cyc;
        logic [23:0] data;
    } read_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [23:0] data;
    } cpu_op_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              hbright, vbright;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_ack, disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .hbright(hbright), .vbright(vbright),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pattern(logic [15:0] a);
        return {a[7:0] ^ 8'h5a, a[15:8], ~a[7:0]};
    endfunction

    // Synchronous RAM, one-cycle read latency; unwritten words read as pattern().
    logic [23:0] ram     [0:65535];
    bit          ram_vld [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]     <= mem_wdata;
                ram_vld[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= ram_vld[mem_addr] ? ram[mem_addr] : pattern(mem_addr);
            end
        end
    end

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          in_reset = 1'b1;
    grant_t      exp_g[$];
    read_t       exp_r[$];
    logic [15:0] disp_q[$];
    cpu_op_t     cpu_q[$];
    logic [23:0] ref_mem [int];
    int          m_last   = 2;
    int          m_starve = 0;
    int          n_dack = 0, n_cack = 0;
    int          ack_log[$], dack_cyc[$], cack_cyc[$], cack_dcnt[$];
    logic [23:0] last_cpu_rdata;
    grant_t      mg;
    read_t       mr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: grant rules applied to the requests presented this cycle.
    task automatic predict();
        int          who = 0;
        logic [23:0] d;
        if (disp_req && cpu_req) begin
            if (hbright && vbright) who = (m_starve >= LIMIT) ? 2 : 1;
            else                    who = (m_last == 1) ? 2 : 1;
        end else if (disp_req) begin
            who = 1;
        end else if (cpu_req) begin
            who = 2;
        end
        if (who == 2 || !cpu_req)              m_starve = 0;
        else if (who == 1 && m_starve < LIMIT) m_starve++;
        if (who == 1) begin
            m_last = 1;
            d = ref_mem.exists(int'(disp_addr)) ? ref_mem[int'(disp_addr)] : pattern(disp_addr);
            exp_g.push_back('{1, cyc + 1, 1'b0, disp_addr, 24'h0});
            exp_r.push_back('{1, cyc + 2, d});
        end else if (who == 2) begin
            m_last = 2;
            exp_g.push_back('{2, cyc + 1, cpu_we, cpu_addr, cpu_wdata});
            if (cpu_we) begin
                ref_mem[int'(cpu_addr)] = cpu_wdata;
            end else begin
                d = ref_mem.exists(int'(cpu_addr)) ? ref_mem[int'(cpu_addr)] : pattern(cpu_addr);
                exp_r.push_back('{2, cyc + 2, d});
            end
        end
    endtask

    task automatic step(input bit hb, input bit vb);
        @(posedge clk);
        #1;
        cyc++;
        if (disp_ack) begin
            n_dack++;
            dack_cyc.push_back(cyc);
            ack_log.push_back(1);
            if (disp_q.size() != 0) void'(disp_q.pop_front());
        end
        if (cpu_ack) begin
            n_cack++;
            cack_cyc.push_back(cyc);
            cack_dcnt.push_back(n_dack);
            ack_log.push_back(2);
            if (cpu_q.size() != 0) void'(cpu_q.pop_front());
        end
        hbright  = hb;
        vbright  = vb;
        disp_req = (disp_q.size() != 0);
        if (disp_req) disp_addr = disp_q[0];
        cpu_req = (cpu_q.size() != 0);
        if (cpu_req) begin
            cpu_we    = cpu_q[0].we;
            cpu_addr  = cpu_q[0].addr;
            cpu_wdata = cpu_q[0].data;
        end
        predict();
    endtask

    task automatic run_until_idle(input int budget, input bit hb, input bit vb);
        int left = budget;
        while ((disp_q.size() + cpu_q.size() + exp_g.size() + exp_r.size()) != 0 && left > 0) begin
            step(hb, vb);
            left--;
        end
        if (left == 0)
            check("drain_timeout", disp_q.size() + cpu_q.size() + exp_g.size() + exp_r.size(), 0);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_disp_ack"}, disp_ack, 0);
        check({pfx, "_disp_rvalid"}, disp_rvalid, 0);
        check({pfx, "_disp_rdata"}, disp_rdata, 0);
        check({pfx, "_cpu_ack"}, cpu_ack, 0);
        check({pfx, "_cpu_rvalid"}, cpu_rvalid, 0);
        check({pfx, "_cpu_rdata"}, cpu_rdata, 0);
        check({pfx, "_mem_en"}, mem_en, 0);
        check({pfx, "_mem_we"}, mem_we, 0);
        check({pfx, "_mem_addr"}, mem_addr, 0);
        check({pfx, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // Monitor: pops expected grants/reads whenever the DUT presents them.
    always @(negedge clk) begin
        if (!in_reset) begin
            while (exp_g.size() != 0 && exp_g[0].cyc < cyc) begin
                check("grant_missing", cyc, exp_g[0].cyc);
                void'(exp_g.pop_front());
            end
            while (exp_r.size() != 0 && exp_r[0].cyc < cyc) begin
                check("rvalid_missing", cyc, exp_r[0].cyc);
                void'(exp_r.pop_front());
            end
            if (disp_ack && cpu_ack) check("single_grant", 2, 1);
            if (disp_ack || cpu_ack) begin
                if (exp_g.size() == 0) begin
                    check("grant_unexpected", disp_ack ? 1 : 2, 0);
                end else begin
                    mg = exp_g.pop_front();
                    check("grant_who", disp_ack ? 1 : 2, mg.who);
                    check("grant_cyc", cyc, mg.cyc);
                    check("grant_mem_en", mem_en, 1);
                    check("grant_mem_we", mem_we, mg.we);
                    check("grant_mem_addr", mem_addr, mg.addr);
                    if (mg.we) check("grant_mem_wdata", mem_wdata, mg.wdata);
                end
            end else begin
                check("idle_mem_en", mem_en, 0);
                check("idle_mem_we", mem_we, 0);
            end
            if (disp_rvalid && cpu_rvalid) check("single_rvalid", 2, 1);
            if (disp_rvalid || cpu_rvalid) begin
                if (cpu_rvalid) last_cpu_rdata = cpu_rdata;
                if (exp_r.size() == 0) begin
                    check("rvalid_unexpected", disp_rvalid ? 1 : 2, 0);
                end else begin
                    mr = exp_r.pop_front();
                    check("rvalid_who", disp_rvalid ? 1 : 2, mr.who);
                    check("rvalid_cyc", cyc, mr.cyc);
                    check("rdata", disp_rvalid ? disp_rdata : cpu_rdata, mr.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          base, d1, c1, left, rv;
        bit          hb, vb;
        rst = 1'b0;
        {hbright, vbright, disp_req, cpu_req, cpu_we} = '0;
        disp_addr = '0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_reset = 1'b0;

        // Blanking, both requesting continuously: strict DISP,CPU alternation.
        ack_log.delete();
        for (int i = 0; i < 6; i++) begin
            disp_q.push_back(16'h0100 + 16'(i));
            cpu_q.push_back('{1'b0, 16'h0200 + 16'(i), 24'h0});
        end
        run_until_idle(100, 1'b0, 1'b0);
        check("blank_grants", ack_log.size(), 12);
        for (int i = 0; i < 12 && i < ack_log.size(); i++)
            check("blank_rr", ack_log[i], (i % 2 == 0) ? 1 : 2);

        // Display burst, no CPU: four back-to-back acks.
        dack_cyc.delete();
        for (int i = 0; i < 4; i++) disp_q.push_back(16'(i));
        run_until_idle(50, 1'b0, 1'b0);
        check("disp_burst_acks", dack_cyc.size(), 4);
        for (int i = 1; i < 4 && i < dack_cyc.size(); i++)
            check("disp_burst_gap", dack_cyc[i] - dack_cyc[0], i);

        // CPU write then read-back.
        last_cpu_rdata = '0;
        cpu_q.push_back('{1'b1, 16'h0010, 24'hFF8000});
        cpu_q.push_back('{1'b0, 16'h0010, 24'h0});
        run_until_idle(50, 1'b0, 1'b0);
        check("cpu_readback", last_cpu_rdata, 24'hFF8000);

        // Active display, both continuous: 8 display grants per CPU grant.
        cack_cyc.delete();
        cack_dcnt.delete();
        base = n_dack;
        for (int i = 0; i < 45; i++) disp_q.push_back(16'($urandom_range(0, 15)));
        for (int i = 0; i < 4; i++) cpu_q.push_back('{1'b0, 16'($urandom_range(0, 15)), 24'h0});
        run_until_idle(200, 1'b1, 1'b1);
        check("active_cpu_acks", cack_cyc.size(), 4);
        if (cack_dcnt.size() != 0) check("active_first_wait", cack_dcnt[0] - base, 8);
        for (int i = 1; i < cack_cyc.size(); i++)
            check("active_cpu_period", cack_cyc[i] - cack_cyc[i-1], 9);

        // CPU withdraws after 5 display grants; a fresh request waits a full 8.
        for (int i = 0; i < 30; i++) disp_q.push_back(16'h0040 + 16'(i));
        cpu_q.push_back('{1'b0, 16'h0020, 24'h0});
        base = n_dack;
        left = 20;
        while (n_dack - base < 5 && left > 0) begin
            step(1'b1, 1'b1);
            left--;
        end
        check("starve_pre_grants", n_dack - base, 5);
        cpu_q.delete();
        step(1'b1, 1'b1);
        cpu_q.push_back('{1'b0, 16'h0021, 24'h0});
        step(1'b1, 1'b1);
        d1 = n_dack;
        c1 = n_cack;
        left = 30;
        while (n_cack == c1 && left > 0) begin
            step(1'b1, 1'b1);
            left--;
        end
        check("starve_restart_wait", n_dack - d1, 8);
        run_until_idle(100, 1'b1, 1'b1);

        // Randomised traffic with mode changes between active and blanking.
        hb = 1'b0;
        vb = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                hb = 1'($urandom_range(0, 1));
                vb = 1'($urandom_range(0, 1));
            end
            if (disp_q.size() < 3 && $urandom_range(0, 1) == 1)
                disp_q.push_back(16'($urandom_range(0, 15)));
            if (cpu_q.size() < 3 && $urandom_range(0, 9) < 3)
                cpu_q.push_back('{1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
                                  24'($urandom)});
            step(hb, vb);
        end
        run_until_idle(200, 1'b0, 1'b0);

        // Reset during the grant cycle of a display read drops the pending return.
        disp_q.push_back(16'h0030);
        disp_q.push_back(16'h0031);
        base = n_dack;
        left = 10;
        while (n_dack == base && left > 0) begin
            step(1'b0, 1'b0);
            left--;
        end
        check("reset_pre_grant", n_dack - base, 1);
        rst = 1'b0;
        in_reset = 1'b1;
        disp_q.delete();
        cpu_q.delete();
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        exp_g.delete();
        exp_r.delete();
        #1;
        check_outputs_zero("midrst");
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("midrst_hold");
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_reset = 1'b0;
        m_last = 2;
        m_starve = 0;
        rv = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            if (disp_rvalid) rv++;
        end
        check("rvalid_after_reset", rv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
